// File: rtl/axis_uart_tx.sv
// -----------------------------------------------------------------------------
// axis_uart_tx
//
// AXI-stream to serial UART transmitter. One DATA_WIDTH word is accepted per
// tvalid/tready handshake and sent on txd, LSB first, in this frame:
//   start bit (0), DATA_WIDTH data bits, optional parity bit, 1 or 2 stop bits (1).
// Each bit lasts prescale*8 clk cycles. A prescale of 0 is treated as 1.
// prescale is sampled only at acceptance.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//   PARITY      0 = none, 1 = odd, 2 = even (any other value = none)
//   STOP_BITS   1 or 2 (any other value = 1)
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   s_axis_tdata   word to transmit
//   s_axis_tvalid  tdata valid
//   s_axis_tready  block can accept a word (registered)
//   txd            serial output, idle high (registered)
//   busy           frame in progress (registered)
//   prescale       bit time = prescale*8 clk cycles
// -----------------------------------------------------------------------------
module axis_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale
);

  // Out-of-range parameter values fall back to no parity and one stop bit.
  localparam logic       PAR_EN    = (PARITY == 1) || (PARITY == 2);
  localparam logic       PAR_ODD   = (PARITY == 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = (STOP_BITS == 2) ? 4'd1 : 4'd0;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [DATA_WIDTH-1:0] shift_q,   shift_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  // 19 bits so that 0xFFFF*8 - 1 fits without wrapping.
  logic [18:0]           cnt_q,     cnt_d;
  logic [15:0]           presc_q,   presc_d;
  logic                  par_q,     par_d;
  logic                  txd_q,     txd_d;
  logic                  tready_q,  tready_d;
  logic                  busy_q,    busy_d;

  logic [15:0] presc_eff;
  logic [18:0] reload;
  logic        cnt_done;

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

  // A zero prescale would give a zero-length bit, so it is promoted to 1.
  assign presc_eff = (prescale == 16'd0) ? 16'd1 : prescale;
  // Reload for bits after the first one uses the prescale latched at acceptance.
  assign reload    = {presc_q, 3'b000} - 19'd1;
  assign cnt_done  = (cnt_q == 19'd0);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    presc_d   = presc_q;
    par_d     = par_q;
    txd_d     = txd_q;
    tready_d  = tready_q;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        // tready rises one edge after reset release and stays up while idle.
        tready_d = 1'b1;
        busy_d   = 1'b0;
        txd_d    = 1'b1;
        if (s_axis_tvalid && tready_q) begin
          presc_d   = presc_eff;
          cnt_d     = {presc_eff, 3'b000} - 19'd1;
          shift_d   = s_axis_tdata;
          par_d     = (^s_axis_tdata) ^ PAR_ODD;
          bit_cnt_d = 4'd0;
          state_d   = ST_START;
          txd_d     = 1'b0;
          tready_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_done) begin
          cnt_d     = reload;
          bit_cnt_d = 4'd0;
          txd_d     = shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = ST_DATA;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_DATA: begin
        if (cnt_done) begin
          cnt_d = reload;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = 4'd0;
            if (PAR_EN) begin
              txd_d   = par_q;
              state_d = ST_PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_PAR: begin
        if (cnt_done) begin
          cnt_d     = reload;
          bit_cnt_d = 4'd0;
          txd_d     = 1'b1;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      ST_STOP: begin
        if (cnt_done) begin
          if (bit_cnt_q == LAST_STOP) begin
            // End of the last stop bit: the following cycle is the acceptance slot.
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            txd_d     = 1'b1;
            tready_d  = 1'b1;
            busy_d    = 1'b0;
          end else begin
            cnt_d     = reload;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        txd_d    = 1'b1;
        tready_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= 4'd0;
      cnt_q     <= 19'd0;
      presc_q   <= 16'd0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      tready_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      tready_q  <= tready_d;
      busy_q    <= busy_d;
    end
  end

endmodule
